// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the LC-3b pipeline control slice.
// Holds the pipeline controller state encoding and the packed view of its
// enable/flush outputs used inside pipe_ctrl.
package lc3b_types;

  typedef enum logic [0:0] {
    RUN           = 1'b0,
    REDIRECT_WAIT = 1'b1
  } pipe_ctrl_state;

  // Bundle of all per-cycle control outputs of the pipeline controller.
  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic redirect_latch;
    logic redirect_pend;
  } pipe_ctrl_out_t;

  localparam int unsigned PERF_CNT_W = 16;

  // Everything advances, nothing is squashed.
  function automatic pipe_ctrl_out_t ctrl_idle();
    pipe_ctrl_out_t o;
    o                = '0;
    o.load_pc        = 1'b1;
    o.load_if_id     = 1'b1;
    o.load_id_ex     = 1'b1;
    o.load_ex_mem    = 1'b1;
    o.load_mem_wb    = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones.
// Used by pipe_ctrl for its optional performance counters.
module sat_counter16
  import lc3b_types::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [PERF_CNT_W-1:0] count
);

  // Count qualified events, saturating at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall / flush / redirect controller for the 5-stage LC-3b pipe.
// Optional performance counters (stall_cycles, flush_count) are built only
// when the macro PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_flush,
  input  logic        if_stall,
  input  logic        mem_stall,
  input  logic        load_use,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        redirect_latch,
  output logic        redirect_pend
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  pipe_ctrl_state state, state_next;
  pipe_ctrl_out_t ctrl;
  logic           flush_accept;

  // State register; reset always returns to RUN, dropping any held redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode in priority order:
  // reset > mem_stall > flush/pending redirect > load_use > if_stall.
  always_comb begin
    ctrl               = ctrl_idle();
    ctrl.redirect_pend = (state == REDIRECT_WAIT);
    state_next         = state;
    flush_accept       = 1'b0;

    if (reset) begin
      ctrl              = '0;
      ctrl.flush_if_id  = 1'b1;
      ctrl.flush_id_ex  = 1'b1;
      ctrl.flush_ex_mem = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything; redirect_pend still reflects the held state.
      ctrl.load_pc     = 1'b0;
      ctrl.load_if_id  = 1'b0;
      ctrl.load_id_ex  = 1'b0;
      ctrl.load_ex_mem = 1'b0;
      ctrl.load_mem_wb = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (wb_flush) begin
            flush_accept      = 1'b1;
            ctrl.flush_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
            ctrl.flush_ex_mem = 1'b1;
            if (if_stall) begin
              // Fetch cannot take the target yet: park it and wait.
              ctrl.load_pc        = 1'b0;
              ctrl.redirect_latch = 1'b1;
              state_next          = REDIRECT_WAIT;
            end
          end else if (load_use) begin
            ctrl.load_pc     = 1'b0;
            ctrl.load_if_id  = 1'b0;
            ctrl.flush_id_ex = 1'b1;
          end else if (if_stall) begin
            ctrl.load_pc     = 1'b0;
            ctrl.flush_if_id = 1'b1;
          end
        end
        REDIRECT_WAIT: begin
          // wb_flush is ignored: only bubbles can be in WB here.
          if (if_stall) begin
            ctrl.load_pc      = 1'b0;
            ctrl.flush_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
            ctrl.flush_ex_mem = 1'b1;
          end else begin
            ctrl.flush_if_id = 1'b1;
            state_next       = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign load_pc        = ctrl.load_pc;
  assign load_if_id     = ctrl.load_if_id;
  assign load_id_ex     = ctrl.load_id_ex;
  assign load_ex_mem    = ctrl.load_ex_mem;
  assign load_mem_wb    = ctrl.load_mem_wb;
  assign flush_if_id    = ctrl.flush_if_id;
  assign flush_id_ex    = ctrl.flush_id_ex;
  assign flush_ex_mem   = ctrl.flush_ex_mem;
  assign redirect_latch = ctrl.redirect_latch;
  assign redirect_pend  = ctrl.redirect_pend;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;

  assign stall_inc = ~ctrl.load_pc & ~reset;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_accept),
    .count (flush_count)
  );
`else
  logic unused_flush_accept;
  assign unused_flush_accept = flush_accept;
`endif

endmodule
